// File: rtl/be8_pkg.sv
// Shared definitions for the be8 CPU control path: control-word bit map,
// idle control word, flag indices and sequencer state encoding.
package be8_pkg;

    localparam int CW_W   = 18;
    localparam int CW_HLT = 17;
    localparam int CW_CE  = 16;
    localparam int CW_SU  = 15;
    localparam int CW_AIN = 14;
    localparam int CW_BIN = 13;
    localparam int CW_OIN = 12;
    localparam int CW_IIN = 11;
    localparam int CW_JN  = 10;
    localparam int CW_FIN = 9;
    localparam int CW_MIN = 8;
    localparam int CW_RI  = 7;
    localparam int CW_AON = 6;
    localparam int CW_BON = 5;
    localparam int CW_ION = 4;
    localparam int CW_CON = 3;
    localparam int CW_EON = 2;
    localparam int CW_RON = 1;
    localparam int CW_NON = 0;

    localparam logic [CW_W-1:0] CW_IDLE = 18'h07F7F;

    localparam int FLG_C = 1;
    localparam int FLG_Z = 0;

    typedef enum logic [0:0] {
        SEQ_RUN  = 1'b0,
        SEQ_HALT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/be8_edge_detect.sv
// Rising-edge detector with a configurable history reset value, so a level
// already high when reset releases is not mistaken for a new edge.
module be8_edge_detect #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev_d;
    logic prev_q;

    // History follows the input every cycle.
    always_comb begin
        prev_d = d;
    end

    // History register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= RST_VAL;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign rise = d & ~prev_q;

endmodule

// File: rtl/be8_sequencer.sv
// Control sequencer for the be8 CPU: IR, flags, microstep counter, halt latch
// and retired-instruction counter, with free-run and single-step advance.
module be8_sequencer
    import be8_pkg::*;
#(
    parameter int STEPS = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step_pulse,
    input  logic [7:0]        bus_in,
    input  logic [CW_W-1:0]   ctrl,
    input  logic              alu_carry,
    input  logic              alu_zero,
    output logic [3:0]        opcode,
    output logic [3:0]        operand,
    output logic [1:0]        flags,
    output logic [1:0]        step,
    output logic              tick,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [1:0]       LAST_STEP = 2'(STEPS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    seq_state_e       state_d, state_q;
    logic [7:0]       ir_d, ir_q;
    logic [1:0]       flags_d, flags_q;
    logic [1:0]       step_d, step_q;
    logic [CNT_W-1:0] retired_d, retired_q;
    logic             step_rise_s;
    logic             adv_s;

    be8_edge_detect #(
        .RST_VAL (1'b1)
    ) u_step_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (step_pulse),
        .rise (step_rise_s)
    );

    // Advance qualification and next-state for all sequencer registers.
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        flags_d   = flags_q;
        step_d    = step_q;
        retired_d = retired_q;
        adv_s     = !rst && (state_q == SEQ_RUN) && (run || step_rise_s);

        if (adv_s) begin
            if (!ctrl[CW_IIN]) begin
                ir_d = bus_in;
            end else begin
                ir_d = ir_q;
            end

            if (!ctrl[CW_FIN]) begin
                flags_d[FLG_C] = alu_carry;
                flags_d[FLG_Z] = alu_zero;
            end else begin
                flags_d = flags_q;
            end

            // HLT outranks end-of-instruction: step holds and nothing retires.
            if (ctrl[CW_HLT]) begin
                state_d = SEQ_HALT;
            end else if (!ctrl[CW_NON] || (step_q == LAST_STEP)) begin
                step_d = 2'd0;
                if (retired_q == CNT_MAX) begin
                    retired_d = retired_q;
                end else begin
                    retired_d = retired_q + CNT_W'(1);
                end
            end else begin
                step_d = step_q + 2'd1;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Sequencer state; halt is left only through rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= SEQ_RUN;
            ir_q      <= 8'h00;
            flags_q   <= 2'b00;
            step_q    <= 2'd0;
            retired_q <= '0;
        end else begin
            case (state_q)
                SEQ_RUN: begin
                    state_q   <= state_d;
                    ir_q      <= ir_d;
                    flags_q   <= flags_d;
                    step_q    <= step_d;
                    retired_q <= retired_d;
                end
                SEQ_HALT: begin
                    state_q <= SEQ_HALT;
                end
                default: begin
                    state_q <= SEQ_HALT;
                end
            endcase
        end
    end

    logic unused_ctrl_s;
    assign unused_ctrl_s = ^{ctrl[CW_CE:CW_OIN], ctrl[CW_JN], ctrl[CW_MIN:CW_RON]};

    assign opcode  = ir_q[7:4];
    assign operand = ir_q[3:0];
    assign flags   = flags_q;
    assign step    = step_q;
    assign halted  = (state_q == SEQ_HALT);
    assign retired = retired_q;
    assign tick    = adv_s;

endmodule
